// File: rtl/approx_mult_pkg.sv
// Shared widths and helpers for the pipelined approximate multiplier.
// Truncation masks are computed per partial-product row from N and T.
package approx_mult_pkg;

  localparam int STAT_W = 32;

  function automatic int kept_w(input int n, input int l);
    return n + l + 1;
  endfunction

  // Bit j of the result is set when bit j of row i lands in a kept column.
  function automatic logic [31:0] trunc_mask(input int row, input int n, input int t);
    logic [31:0] m;
    m = '0;
    for (int j = 0; j < 32; j++) begin
      m[j] = (j < n) && ((row + j) >= t);
    end
    return m;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_reduce.sv
// Combinational partial-product reduction: aligned exact high product plus
// the low-row sum, with columns below T discarded in approximate mode.
module approx_pp_reduce
  import approx_mult_pkg::*;
#(
  parameter int N = 8,
  parameter int L = 4,
  parameter int T = N - 1
) (
  input  logic [N-1:0]              x,
  input  logic [N-1:0]              y,
  input  logic                      exact,
  output logic [2*N-1:0]            hi_sh,
  output logic [kept_w(N, L)-1:0]   lo_sum
);

  localparam int KW = kept_w(N, L);
  localparam int ZW = 2 * N;

  logic [ZW-1:0] hi_prod;
  logic [N-1:0]  row;
  logic [N-1:0]  mask;
  logic [KW-1:0] lo_acc;

  always_comb begin
    hi_prod = ZW'(y) * ZW'(x[N-1:L]);
    hi_sh   = hi_prod << L;
  end

  always_comb begin
    row    = '0;
    mask   = '0;
    lo_acc = '0;
    for (int i = 0; i < L; i++) begin
      mask = exact ? {N{1'b1}} : N'(trunc_mask(i, N, T));
      row  = y & {N{x[i]}} & mask;
      lo_acc = lo_acc + (KW'(row) << i);
    end
    lo_sum = lo_acc;
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage valid/ready N x N multiplier with per-transaction exact/approx mode.
// Optional error statistics are compiled in with APPROX_MULT_ERR_STAT_EN.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int N = 8,
  parameter int L = 4,
  parameter int T = N - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_x,
  input  logic [N-1:0]       in_y,
  input  logic               in_exact,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*N-1:0]     out_z,
  output logic               out_exact
`ifdef APPROX_MULT_ERR_STAT_EN
  ,
  output logic [STAT_W-1:0]  err_sum,
  output logic [STAT_W-1:0]  txn_cnt
`endif
);

  localparam int KW = kept_w(N, L);
  localparam int ZW = 2 * N;

  logic          s1_vld_q, s1_vld_d;
  logic [N-1:0]  s1_x_q, s1_x_d;
  logic [N-1:0]  s1_y_q, s1_y_d;
  logic          s1_exact_q, s1_exact_d;

  logic          s2_vld_q, s2_vld_d;
  logic [ZW-1:0] s2_hi_q, s2_hi_d;
  logic [KW-1:0] s2_lo_q, s2_lo_d;
  logic          s2_exact_q, s2_exact_d;

  logic          s3_vld_q, s3_vld_d;
  logic [ZW-1:0] s3_z_q, s3_z_d;
  logic          s3_exact_q, s3_exact_d;

  logic          in_fire, out_fire, s1_adv, s2_adv, s2_ld_ok, s3_ld_ok;
  logic [ZW-1:0] red_hi, z_sum;
  logic [KW-1:0] red_lo;

  approx_pp_reduce #(.N(N), .L(L), .T(T)) u_reduce (
    .x      (s1_x_q),
    .y      (s1_y_q),
    .exact  (s1_exact_q),
    .hi_sh  (red_hi),
    .lo_sum (red_lo)
  );

  // Each stage may load when empty or when its occupant moves on this cycle.
  always_comb begin
    out_fire = s3_vld_q & out_ready;
    s3_ld_ok = ~s3_vld_q | out_ready;
    s2_adv   = s2_vld_q & s3_ld_ok;
    s2_ld_ok = ~s2_vld_q | s3_ld_ok;
    s1_adv   = s1_vld_q & s2_ld_ok;
    in_ready = ~s1_vld_q | s2_ld_ok;
    in_fire  = in_valid & in_ready;
  end

  always_comb begin
    z_sum = s2_hi_q + ZW'(s2_lo_q);

    s1_vld_d   = s1_vld_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_exact_d = s1_exact_q;
    s2_vld_d   = s2_vld_q;
    s2_hi_d    = s2_hi_q;
    s2_lo_d    = s2_lo_q;
    s2_exact_d = s2_exact_q;
    s3_vld_d   = s3_vld_q;
    s3_z_d     = s3_z_q;
    s3_exact_d = s3_exact_q;

    if (in_fire) begin
      s1_vld_d   = 1'b1;
      s1_x_d     = in_x;
      s1_y_d     = in_y;
      s1_exact_d = in_exact;
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end

    if (s1_adv) begin
      s2_vld_d   = 1'b1;
      s2_hi_d    = red_hi;
      s2_lo_d    = red_lo;
      s2_exact_d = s1_exact_q;
    end else if (s2_adv) begin
      s2_vld_d = 1'b0;
    end

    if (s2_adv) begin
      s3_vld_d   = 1'b1;
      s3_z_d     = z_sum;
      s3_exact_d = s2_exact_q;
    end else if (out_fire) begin
      s3_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_exact_q <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_hi_q    <= '0;
      s2_lo_q    <= '0;
      s2_exact_q <= 1'b0;
      s3_vld_q   <= 1'b0;
      s3_z_q     <= '0;
      s3_exact_q <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_exact_q <= s1_exact_d;
      s2_vld_q   <= s2_vld_d;
      s2_hi_q    <= s2_hi_d;
      s2_lo_q    <= s2_lo_d;
      s2_exact_q <= s2_exact_d;
      s3_vld_q   <= s3_vld_d;
      s3_z_q     <= s3_z_d;
      s3_exact_q <= s3_exact_d;
    end
  end

  assign out_valid = s3_vld_q;
  assign out_z     = s3_z_q;
  assign out_exact = s3_exact_q;

`ifdef APPROX_MULT_ERR_STAT_EN
  localparam int AW = ((ZW > STAT_W) ? ZW : STAT_W) + 1;

  logic [ZW-1:0]     s2_prod_q, s2_prod_d;
  logic [ZW-1:0]     s3_diff_q, s3_diff_d;
  logic [STAT_W-1:0] err_sum_q, err_sum_d;
  logic [STAT_W-1:0] txn_cnt_q, txn_cnt_d;
  logic [AW-1:0]     err_acc;

  // Approx never exceeds exact, so the difference is a plain unsigned subtract.
  always_comb begin
    s2_prod_d = s1_adv ? ZW'(s1_x_q) * ZW'(s1_y_q) : s2_prod_q;
    s3_diff_d = s2_adv ? s2_prod_q - z_sum : s3_diff_q;
    err_acc   = AW'(err_sum_q) + AW'(s3_diff_q);
    err_sum_d = err_sum_q;
    txn_cnt_d = txn_cnt_q;
    if (out_fire && !s3_exact_q) begin
      err_sum_d = (|err_acc[AW-1:STAT_W]) ? {STAT_W{1'b1}} : err_acc[STAT_W-1:0];
      txn_cnt_d = (&txn_cnt_q) ? txn_cnt_q : txn_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_prod_q <= '0;
      s3_diff_q <= '0;
      err_sum_q <= '0;
      txn_cnt_q <= '0;
    end else begin
      s2_prod_q <= s2_prod_d;
      s3_diff_q <= s3_diff_d;
      err_sum_q <= err_sum_d;
      txn_cnt_q <= txn_cnt_d;
    end
  end

  assign err_sum = err_sum_q;
  assign txn_cnt = txn_cnt_q;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed bench for approx_mult_pipe at N=8, L=4, T=7: vector table, streaming,
// backpressure and reset-flush sequences; statistics checks with APPROX_MULT_ERR_STAT_EN.
module tb_approx_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_exact;
  logic [7:0]  in_x, in_y;
  logic        out_valid, out_ready, out_exact;
  logic [15:0] out_z;
`ifdef APPROX_MULT_ERR_STAT_EN
  logic [31:0] err_sum, txn_cnt;
`endif

  approx_mult_pipe #(.N(8), .L(4), .T(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_exact  (in_exact),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_exact (out_exact)
`ifdef APPROX_MULT_ERR_STAT_EN
    ,
    .err_sum   (err_sum),
    .txn_cnt   (txn_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        e;
    logic [15:0] z;
  } vec_t;

  vec_t        vec [12];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [16:0] exp_q [$];
  int          acc_cnt, out_cnt, cyc, first_out, last_out;
  logic        last_in_fire;

  // Bit-level reference: low rows keep only bits landing in column >= 7.
  function automatic logic [15:0] model_z(input logic [7:0] x, input logic [7:0] y, input logic e);
    logic [15:0] z;
    z = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (x[i] && y[j] && (e || i >= 4 || (i + j) >= 7))
          z = z + (16'd1 << (i + j));
    return z;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, then account for the transfers of the next posedge.
  task automatic step(input logic v, input logic [7:0] x, input logic [7:0] y,
                      input logic e, input logic r);
    logic [16:0] ent;
    @(negedge clk);
    in_valid = v; in_x = x; in_y = y; in_exact = e; out_ready = r;
    #1;
    cyc++;
    last_in_fire = in_valid && in_ready;
    if (last_in_fire) begin
      exp_q.push_back({e, model_z(x, y, e)});
      acc_cnt++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_out: got z=%0d with no pending transaction", out_z);
      end else begin
        ent = exp_q.pop_front();
        chk("seq_z", 64'(out_z), 64'(ent[15:0]));
        chk("seq_exact", 64'(out_exact), 64'(ent[16]));
      end
      if (out_cnt == 0) first_out = cyc;
      last_out = cyc;
      out_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] sx [6];
    logic [7:0] sy [6];
    int lat, idx;

    vec[0]  = '{8'hFF, 8'hFF, 1'b0, 16'd64528};
    vec[1]  = '{8'hFF, 8'hFF, 1'b1, 16'd65025};
    vec[2]  = '{8'h0F, 8'h0F, 1'b0, 16'd0};
    vec[3]  = '{8'h10, 8'h03, 1'b0, 16'd48};
    vec[4]  = '{8'h0F, 8'h0F, 1'b1, 16'd225};
    vec[5]  = '{8'h01, 8'h80, 1'b0, 16'd128};
    vec[6]  = '{8'h01, 8'h7F, 1'b0, 16'd0};
    vec[7]  = '{8'h08, 8'h10, 1'b0, 16'd128};
    vec[8]  = '{8'h08, 8'h0F, 1'b0, 16'd0};
    vec[9]  = '{8'h80, 8'h80, 1'b0, 16'd16384};
    vec[10] = '{8'hA5, 8'h3C, 1'b1, 16'd9900};
    vec[11] = '{8'hA5, 8'h3C, 1'b0, 16'd9728};

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_exact = 1'b0; out_ready = 1'b0;
    acc_cnt = 0; out_cnt = 0; cyc = 0; first_out = 0; last_out = 0; last_in_fire = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_z", 64'(out_z), 64'd0);
    chk("rst_out_exact", 64'(out_exact), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef APPROX_MULT_ERR_STAT_EN
    chk("rst_err_sum", 64'(err_sum), 64'd0);
    chk("rst_txn_cnt", 64'(txn_cnt), 64'd0);
`endif

    // Single transactions: latency, value and mode bit.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_x = vec[k].x; in_y = vec[k].y; in_exact = vec[k].e; out_ready = 1'b1;
      #1;
      chk("vec_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("vec_latency", 64'(lat), 64'd3);
      chk("vec_z", 64'(out_z), 64'(vec[k].z));
      chk("vec_exact", 64'(out_exact), 64'(vec[k].e));
    end
    repeat (2) @(posedge clk);

    // Back-to-back stream with random operands and modes.
    acc_cnt = 0; out_cnt = 0;
    for (int k = 0; k < 20; k++)
      step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    for (int k = 0; k < 10 && out_cnt < 20; k++)
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("stream_accepted", 64'(acc_cnt), 64'd20);
    chk("stream_results", 64'(out_cnt), 64'd20);
    chk("stream_throughput", 64'(last_out - first_out), 64'd19);

    // Backpressure: five stalled cycles, then release.
    sx = '{8'h3A, 8'hC7, 8'h5F, 8'hE1, 8'h0B, 8'h99};
    sy = '{8'h6D, 8'h12, 8'hF0, 8'h87, 8'hFF, 8'h44};
    acc_cnt = 0; out_cnt = 0; idx = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, sx[idx], sy[idx], 1'b0, 1'b0);
      if (last_in_fire) idx++;
      if (out_valid)
        chk("stall_hold_z", 64'(out_z), 64'(model_z(sx[0], sy[0], 1'b0)));
    end
    chk("stall_accepted", 64'(acc_cnt), 64'd3);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, sx[idx], sy[idx], 1'b0, 1'b1);
    chk("release_accept", 64'(last_in_fire), 64'd1);
    if (last_in_fire) idx++;
    for (int k = 0; k < 12 && idx < 6; k++) begin
      step(1'b1, sx[idx], sy[idx], 1'b0, 1'b1);
      if (last_in_fire) idx++;
    end
    for (int k = 0; k < 10 && out_cnt < 6; k++)
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("stall_results", 64'(out_cnt), 64'd6);
    chk("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with two transactions in flight, one already presented at the output.
    step(1'b1, 8'h77, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h21, 8'h9C, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_z", 64'(out_z), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_cnt = 0;
    for (int k = 0; k < 6; k++)
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("flush_no_stale", 64'(out_cnt), 64'd0);

`ifdef APPROX_MULT_ERR_STAT_EN
    step(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
    step(1'b1, 8'h0F, 8'h0F, 1'b0, 1'b1);
    step(1'b1, 8'h01, 8'h01, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++)
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("stat_err_sum", 64'(err_sum), 64'd722);
    chk("stat_txn_cnt", 64'(txn_cnt), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
